// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue with pipelined imem requests and redirect flush
// Optional same-cycle response-to-decode bypass: FETCH_QUEUE_BYPASS_EN
module fetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [31:0]                imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [31:0]                deq_pc,
  output logic [31:0]                deq_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [OW:0]   MAX_C   = (OW+1)'(MAX_OUTSTANDING);

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PW-1:0]    head, tail, fill_ptr;
  logic [31:0]      fetch_pc;
  logic [OW-1:0]    outstanding, drop_cnt;

  logic [OW:0] in_flight;
  logic        accept, rsp_keep, head_filled, bypass, deq_fire;
  logic        unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Dropped requests still occupy imem slots, so they count against the limit.
  assign in_flight      = {1'b0, outstanding} + {1'b0, drop_cnt};
  assign imem_req_valid = !rst && !redirect_valid && (count < DEPTH_C) && (in_flight < MAX_C);
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign head_filled    = (count != '0) && filled[head];

`ifdef FETCH_QUEUE_BYPASS_EN
  // Single unfilled entry means fill_ptr == head, so the arriving word is the head's.
  assign bypass = (count == CW'(1)) && !filled[head] && (drop_cnt == '0) &&
                  imem_rsp_valid && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  assign deq_valid = (head_filled && !redirect_valid) || bypass;
  assign deq_pc    = pc_mem[head];
  assign deq_instr = bypass ? imem_rsp_data : instr_mem[head];
  assign deq_fire  = deq_valid && deq_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      filled      <= '0;
      count       <= '0;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      filled      <= '0;
      count       <= '0;
      fetch_pc    <= {redirect_pc[31:2], 2'b00};
      outstanding <= '0;
      drop_cnt    <= drop_cnt + outstanding - OW'(imem_rsp_valid);
    end else begin
      if (accept) begin
        pc_mem[tail] <= fetch_pc;
        filled[tail] <= 1'b0;
        tail         <= tail + 1'b1;
        fetch_pc     <= fetch_pc + 32'd4;
      end
      if (imem_rsp_valid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - 1'b1;
      if (rsp_keep) begin
        instr_mem[fill_ptr] <= imem_rsp_data;
        filled[fill_ptr]    <= 1'b1;
        fill_ptr            <= fill_ptr + 1'b1;
      end
      if (deq_fire)
        head <= head + 1'b1;
      count       <= count + CW'(accept) - CW'(deq_fire);
      outstanding <= outstanding + OW'(accept) - OW'(rsp_keep);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed vector table plus randomized run against a queue-based model
module tb_fetch_queue;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, redirect_valid, imem_req_valid, imem_req_ready;
  logic        imem_rsp_valid, deq_valid, deq_ready;
  logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, deq_pc, deq_instr;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc), .deq_instr(deq_instr),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return {pc[15:0] ^ 16'h5a3c, ~pc[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    redirect_valid = 0; redirect_pc = 0; imem_req_ready = 0;
    imem_rsp_valid = 0; imem_rsp_data = 0; deq_ready = 0;
  endtask

  // Leaves rst high; the caller's next drive phase releases it.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; drive_idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_req_valid", 32'(imem_req_valid), 0);
      check("rst_deq_valid", 32'(deq_valid), 0);
      check("rst_count", 32'(count), 0);
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    bit rdy; bit rv; logic [31:0] raddr; bit dr; bit red; logic [31:0] rpc;
    bit erv; logic [31:0] eaddr; bit edv; logic [31:0] edpc; int ecnt;
  } vec_t;
  vec_t tbl[18];
  int   n_vec = 0;

  task automatic add(input bit rdy, input bit rv, input logic [31:0] raddr, input bit dr,
                     input bit red, input logic [31:0] rpc, input bit erv, input logic [31:0] eaddr,
                     input bit edv, input logic [31:0] edpc, input int ecnt);
    tbl[n_vec] = '{rdy, rv, raddr, dr, red, rpc, erv, eaddr, edv, edpc, ecnt};
    n_vec++;
  endtask

  typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } entry_t;
  typedef struct { logic [31:0] addr; bit stale; int due; } pend_t;
  entry_t q[$];
  pend_t  pend[$];

  initial begin
    logic [31:0] fpc, exp_instr;
    bit          e_req, e_dv, stale, acc;
    int          cyc, n_deq;
    pend_t       p;

    rst = 1; drive_idle();

    // Fill to full with decode stalled, drain, redirect with drops, stalled accept, bypass.
    add(1,0,0,      0,0,0,        1,32'h0,  0,   0,      0);
    add(1,1,0,      0,0,0,        1,32'h4,  BYP, 0,      1);
    add(1,1,4,      0,0,0,        1,32'h8,  1,   0,      2);
    add(1,1,8,      0,0,0,        1,32'hC,  1,   0,      3);
    add(1,1,32'hC,  0,0,0,        0,0,      1,   0,      4);
    add(1,0,0,      0,0,0,        0,0,      1,   0,      4);
    add(1,0,0,      1,0,0,        0,0,      1,   0,      4);
    add(0,0,0,      1,0,0,        1,32'h10, 1,   4,      3);
    add(1,0,0,      0,0,0,        1,32'h10, 1,   8,      2);
    add(1,0,0,      0,0,0,        1,32'h14, 1,   8,      3);
    add(1,1,32'h10, 1,1,32'h102,  0,0,      0,   0,      4);
    add(1,1,32'h14, 0,0,0,        1,32'h100,0,   0,      0);
    add(0,1,32'h100,0,0,0,        1,32'h104,BYP, 32'h100,1);
    add(0,0,0,      1,0,0,        1,32'h104,1,   32'h100,1);
    add(0,0,0,      0,0,0,        1,32'h104,0,   0,      0);
    add(1,0,0,      0,0,0,        1,32'h104,0,   0,      0);
    add(0,1,32'h104,1,0,0,        1,32'h108,BYP, 32'h104,1);
    add(0,0,0,      1,0,0,        1,32'h108,!BYP,32'h104,BYP ? 0 : 1);

    do_reset();
    for (int i = 0; i < n_vec; i++) begin
      rst = 0;
      imem_req_ready = tbl[i].rdy;
      imem_rsp_valid = tbl[i].rv;
      imem_rsp_data  = tbl[i].rv ? word_of(tbl[i].raddr) : 32'h0;
      deq_ready      = tbl[i].dr;
      redirect_valid = tbl[i].red;
      redirect_pc    = tbl[i].rpc;
      @(negedge clk);
      check($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].erv));
      if (tbl[i].erv) check($sformatf("v%0d_req_addr", i), imem_req_addr, tbl[i].eaddr);
      check($sformatf("v%0d_deq_valid", i), 32'(deq_valid), 32'(tbl[i].edv));
      if (tbl[i].edv) begin
        check($sformatf("v%0d_deq_pc", i), deq_pc, tbl[i].edpc);
        check($sformatf("v%0d_deq_instr", i), deq_instr, word_of(tbl[i].edpc));
      end
      check($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].ecnt));
      @(posedge clk); #1;
    end

    // Randomized run: model is a queue of reserved fetches and a queue of imem requests in flight.
    do_reset();
    q.delete(); pend.delete();
    fpc = 32'h0; cyc = 0; n_deq = 0;
    for (int k = 0; k < 3000; k++) begin
      rst            = 0;
      imem_req_ready = ($urandom_range(3) != 0);
      deq_ready      = ($urandom_range(2) != 0);
      redirect_valid = ($urandom_range(24) == 0);
      redirect_pc    = $urandom;
      imem_rsp_valid = (pend.size() > 0) && (pend[0].due <= cyc) && ($urandom_range(3) != 0);
      imem_rsp_data  = imem_rsp_valid ? word_of(pend[0].addr) : $urandom;
      @(negedge clk);

      e_req = !redirect_valid && (q.size() < DEPTH) && (pend.size() < MAX_OUT);
      check("rnd_req_valid", 32'(imem_req_valid), 32'(e_req));
      if (e_req) check("rnd_req_addr", imem_req_addr, fpc);
      check("rnd_count", 32'(count), 32'(q.size()));

      stale = imem_rsp_valid && pend[0].stale;
      e_dv  = !redirect_valid && (q.size() > 0) && q[0].filled;
      if (BYP && !redirect_valid && q.size() == 1 && !q[0].filled && imem_rsp_valid && !stale)
        e_dv = 1;
      check("rnd_deq_valid", 32'(deq_valid), 32'(e_dv));
      if (e_dv) begin
        exp_instr = q[0].filled ? q[0].instr : imem_rsp_data;
        check("rnd_deq_pc", deq_pc, q[0].pc);
        check("rnd_deq_instr", deq_instr, exp_instr);
      end

      if (redirect_valid) begin
        q.delete();
        foreach (pend[j]) pend[j].stale = 1;
        if (imem_rsp_valid) void'(pend.pop_front());
        fpc = {redirect_pc[31:2], 2'b00};
      end else begin
        acc = e_req && imem_req_ready;
        if (imem_rsp_valid) begin
          p = pend.pop_front();
          if (!p.stale) begin
            for (int j = 0; j < q.size(); j++)
              if (!q[j].filled) begin
                q[j].filled = 1; q[j].instr = imem_rsp_data;
                break;
              end
          end
        end
        if (e_dv && deq_ready) begin
          void'(q.pop_front());
          n_deq++;
        end
        if (acc) begin
          pend.push_back('{fpc, 1'b0, cyc + 1});
          q.push_back('{fpc, 32'h0, 1'b0});
          fpc = fpc + 32'd4;
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if (n_deq < 100) begin
      errors++;
      $display("FAIL rnd_progress: got %0d dequeues expected at least 100", n_deq);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
